// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a show-ahead byte FIFO: start bit, 8 data bits LSB
// first, optional parity, 1 or 2 stop bits, with one idle cycle between frames.
module fifo_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter bit          PARITY_EN    = 1'b0,
   parameter bit          PARITY_ODD   = 1'b0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_en,
   input  logic [7:0] fifo_dout,
   input  logic       fifo_empty,
   output logic       fifo_read,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

   state_t      state, state_next;
   logic [15:0] baud_cnt, baud_next;
   logic [2:0]  bit_cnt, bit_next;
   logic        stop_cnt, stop_next;
   logic [7:0]  shift_reg, shift_next;
   logic        parity_bit, parity_next;
   logic        tx_next, busy_next, done_next;
   logic        bit_end;

   assign bit_end = (baud_cnt == BAUD_LAST);

   // Pop the head byte on the same edge that latches it; never outside IDLE.
   assign fifo_read = (state == IDLE) && tx_en && !fifo_empty && !rst;

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_next  = state;
      baud_next   = baud_cnt;
      bit_next    = bit_cnt;
      stop_next   = stop_cnt;
      shift_next  = shift_reg;
      parity_next = parity_bit;
      tx_next     = tx;
      busy_next   = busy;
      done_next   = 1'b0;

      if (state != IDLE) begin
         baud_next = bit_end ? 16'd0 : baud_cnt + 16'd1;
      end

      case (state)
         IDLE: begin
            tx_next = 1'b1;
            if (fifo_read) begin
               shift_next  = fifo_dout;
               parity_next = (^fifo_dout) ^ PARITY_ODD;
               busy_next   = 1'b1;
               tx_next     = 1'b0;
               baud_next   = 16'd0;
               bit_next    = 3'd0;
               stop_next   = 1'b0;
               state_next  = START;
            end
         end
         START: begin
            if (bit_end) begin
               tx_next    = shift_reg[0];
               state_next = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_next = {1'b0, shift_reg[7:1]};
               bit_next   = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  if (PARITY_EN) begin
                     tx_next    = parity_bit;
                     state_next = PARITY;
                  end else begin
                     tx_next    = 1'b1;
                     state_next = STOP;
                  end
               end else begin
                  // tx is registered, so present the next bit one edge early.
                  tx_next = shift_reg[1];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               tx_next    = 1'b1;
               state_next = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (stop_cnt == STOP_LAST) begin
                  tx_next    = 1'b1;
                  busy_next  = 1'b0;
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  stop_next = stop_cnt + 1'b1;
               end
            end
         end
         default: begin
            tx_next    = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples the pre-edge value of every other.
      if (rst) begin
         state      <= IDLE;
         baud_cnt   <= 16'd0;
         bit_cnt    <= 3'd0;
         stop_cnt   <= 1'b0;
         shift_reg  <= 8'd0;
         parity_bit <= 1'b0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         tx_done    <= 1'b0;
      end else begin
         state      <= state_next;
         baud_cnt   <= baud_next;
         bit_cnt    <= bit_next;
         stop_cnt   <= stop_next;
         shift_reg  <= shift_next;
         parity_bit <= parity_next;
         tx         <= tx_next;
         busy       <= busy_next;
         tx_done    <= done_next;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: instance 0 is 8N1, instance 1 is 8E2, both at 4 clocks
// per bit, compared every cycle against a frame-level model fed by a byte queue.
module tb_fifo_uart_tx;

   localparam int CPB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [1:0]      tx_en, fifo_empty, fifo_read, tx, busy, tx_done;
   logic [1:0][7:0] fifo_dout;

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut (
      .clk(clk), .rst(rst), .tx_en(tx_en[0]), .fifo_dout(fifo_dout[0]), .fifo_empty(fifo_empty[0]),
      .fifo_read(fifo_read[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0]));

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) dut_par (
      .clk(clk), .rst(rst), .tx_en(tx_en[1]), .fifo_dout(fifo_dout[1]), .fifo_empty(fifo_empty[1]),
      .fifo_read(fifo_read[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1]));

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Requested inputs, applied to the DUTs at the next falling edge.
   bit       rst_req = 1'b1;
   bit [1:0] en_req  = 2'b00;
   bit [1:0] garbage = 2'b00;

   // Reference model: a frame is a list of line levels, one per clock.
   int  par_en [2] = '{0, 1};
   int  stop_n [2] = '{1, 2};
   bit  in_frame [2];
   bit  done_exp [2];
   int  pos [2];
   int  flen [2];
   bit  fb [2][64];
   int  read_cnt [2];
   logic [7:0] q0[$];
   logic [7:0] q1[$];

   // Observed / expected, packed as {fifo_read, tx, busy, tx_done}, two bits each.
   logic [7:0] obs, expv;
   logic [1:0] e_read, e_tx, e_busy, e_done;

   function automatic int q_size(int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [7:0] q_front(int i);
      return (i == 0) ? q0[0] : q1[0];
   endfunction

   function automatic void q_pop(int i);
      if (i == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
   endfunction

   function automatic void build_frame(int i, logic [7:0] b);
      bit bits[$];
      bits.push_back(1'b0);
      for (int k = 0; k < 8; k++) bits.push_back(b[k]);
      if (par_en[i] != 0) bits.push_back(^b);
      for (int s = 0; s < stop_n[i]; s++) bits.push_back(1'b1);
      flen[i] = bits.size() * CPB;
      for (int k = 0; k < flen[i]; k++) fb[i][k] = bits[k / CPB];
   endfunction

   // One clock: drive inputs at the falling edge, sample, then advance the model.
   task automatic step();
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
         e_tx[i]   = in_frame[i] ? fb[i][pos[i]] : 1'b1;
         e_busy[i] = in_frame[i];
         e_done[i] = done_exp[i];
      end
      rst = rst_req;
      for (int i = 0; i < 2; i++) begin
         tx_en[i] = en_req[i];
         if (in_frame[i] && garbage[i]) begin
            fifo_empty[i] = 1'($urandom_range(0, 1));
            fifo_dout[i]  = 8'($urandom);
         end else begin
            fifo_empty[i] = (q_size(i) == 0);
            fifo_dout[i]  = (q_size(i) != 0) ? q_front(i) : 8'($urandom);
         end
         e_read[i] = !in_frame[i] && en_req[i] && (q_size(i) != 0) && !rst_req;
      end
      #1;
      obs  = {fifo_read, tx, busy, tx_done};
      expv = {e_read, e_tx, e_busy, e_done};
      for (int i = 0; i < 2; i++) begin
         if (fifo_read[i] === 1'b1) read_cnt[i]++;
         if (rst_req) begin
            in_frame[i] = 1'b0;
            done_exp[i] = 1'b0;
         end else if (e_read[i]) begin
            build_frame(i, q_front(i));
            q_pop(i);
            in_frame[i] = 1'b1;
            pos[i]      = 0;
            done_exp[i] = 1'b0;
         end else if (in_frame[i]) begin
            if (pos[i] == flen[i] - 1) begin
               in_frame[i] = 1'b0;
               done_exp[i] = 1'b1;
            end else begin
               pos[i]++;
               done_exp[i] = 1'b0;
            end
         end else begin
            done_exp[i] = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst_req = 1'b1;
      step();
      repeat (3) begin
         step();
         n_checks++;
         if (obs !== expv) begin n_fail++; $display("FAIL reset cyc %0d: got %b expected %b", cyc, obs, expv); end
      end
      n_checks++;
      if ({tx, busy, tx_done} !== 6'b11_00_00) begin
         n_fail++; $display("FAIL reset_state: got %b expected 110000", {tx, busy, tx_done});
      end
      rst_req = 1'b0;
   endtask

   task automatic test_single();
      int rc = read_cnt[0];
      int rd = 0, dn = 0, bcnt = 0;
      q0.push_back(8'hA5);
      en_req[0] = 1'b1;
      repeat (50) begin
         step();
         n_checks++;
         if (obs !== expv) begin n_fail++; $display("FAIL single_a5 cyc %0d: got %b expected %b", cyc, obs, expv); end
         if (obs[6]) rd = cyc;
         if (obs[0]) dn = cyc;
         if (obs[2]) bcnt++;
      end
      en_req[0] = 1'b0;
      n_checks++;
      if (read_cnt[0] - rc !== 1) begin n_fail++; $display("FAIL single_reads: got %0d expected 1", read_cnt[0] - rc); end
      n_checks++;
      if (bcnt !== 40) begin n_fail++; $display("FAIL single_busy_len: got %0d expected 40", bcnt); end
      // tx_done is set on the 40th edge after the read edge, visible in the cycle after it.
      n_checks++;
      if (dn - rd !== 41) begin n_fail++; $display("FAIL single_done_pos: got %0d expected 41", dn - rd); end
   endtask

   task automatic test_back_to_back();
      int rc = read_cnt[0];
      int rcyc[$];
      q0.push_back(8'h00);
      q0.push_back(8'hFF);
      q0.push_back(8'h3C);
      en_req[0] = 1'b1;
      repeat (3 * 41 + 20) begin
         step();
         n_checks++;
         if (obs !== expv) begin n_fail++; $display("FAIL b2b cyc %0d: got %b expected %b", cyc, obs, expv); end
         if (obs[6]) rcyc.push_back(cyc);
      end
      en_req[0] = 1'b0;
      n_checks++;
      if (read_cnt[0] - rc !== 3) begin n_fail++; $display("FAIL b2b_reads: got %0d expected 3", read_cnt[0] - rc); end
      for (int k = 1; k < rcyc.size(); k++) begin
         n_checks++;
         if (rcyc[k] - rcyc[k-1] !== 41) begin
            n_fail++; $display("FAIL b2b_spacing %0d: got %0d expected 41", k, rcyc[k] - rcyc[k-1]);
         end
      end
   endtask

   task automatic test_parity();
      int rc = read_cnt[1];
      int rd = -100, nrd = 0;
      bit exp_par [2] = '{1'b0, 1'b1};
      q1.push_back(8'hA5);
      q1.push_back(8'h07);
      en_req[1] = 1'b1;
      repeat (2 * 49 + 20) begin
         step();
         n_checks++;
         if (obs !== expv) begin n_fail++; $display("FAIL parity cyc %0d: got %b expected %b", cyc, obs, expv); end
         if (obs[7]) begin rd = cyc; nrd++; end
         // Parity is bit 9 of the frame: cycles rd+37..rd+40.
         if (cyc == rd + 38 && nrd >= 1 && nrd <= 2) begin
            n_checks++;
            if (tx[1] !== exp_par[nrd-1]) begin
               n_fail++; $display("FAIL parity_bit %0d: got %b expected %b", nrd, tx[1], exp_par[nrd-1]);
            end
         end
         if (nrd == 2 && cyc == rd) begin
            n_checks++;
            if (obs[1] !== 1'b1) begin n_fail++; $display("FAIL parity_spacing: got tx_done %b expected 1 at read", obs[1]); end
         end
      end
      en_req[1] = 1'b0;
      n_checks++;
      if (read_cnt[1] - rc !== 2) begin n_fail++; $display("FAIL parity_reads: got %0d expected 2", read_cnt[1] - rc); end
   endtask

   task automatic test_tx_en();
      int rc = read_cnt[0];
      q0.push_back(8'h11);
      q0.push_back(8'h22);
      en_req[0] = 1'b0;
      repeat (10) begin
         step();
         n_checks++;
         if (obs !== expv) begin n_fail++; $display("FAIL txen_off cyc %0d: got %b expected %b", cyc, obs, expv); end
      end
      n_checks++;
      if ({fifo_read[0], tx[0], busy[0]} !== 3'b010) begin
         n_fail++; $display("FAIL txen_idle: got %b expected 010", {fifo_read[0], tx[0], busy[0]});
      end
      en_req[0] = 1'b1;
      step();
      n_checks++;
      if (obs[6] !== 1'b1) begin n_fail++; $display("FAIL txen_same_cycle_read: got %b expected 1", obs[6]); end
      repeat (19) begin
         step();
         n_checks++;
         if (obs !== expv) begin n_fail++; $display("FAIL txen_on cyc %0d: got %b expected %b", cyc, obs, expv); end
      end
      en_req[0] = 1'b0;
      repeat (60) begin
         step();
         n_checks++;
         if (obs !== expv) begin n_fail++; $display("FAIL txen_drop cyc %0d: got %b expected %b", cyc, obs, expv); end
      end
      n_checks++;
      if (read_cnt[0] - rc !== 1) begin n_fail++; $display("FAIL txen_reads: got %0d expected 1", read_cnt[0] - rc); end
      q0.delete();
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      q0.push_back(8'h55);
      en_req[0] = 1'b1;
      repeat (20) begin
         step();
         n_checks++;
         if (obs !== expv) begin n_fail++; $display("FAIL rstmid_pre cyc %0d: got %b expected %b", cyc, obs, expv); end
      end
      rst_req = 1'b1;
      step();
      rst_req = 1'b0;
      repeat (40) begin
         step();
         n_checks++;
         if (obs !== expv) begin n_fail++; $display("FAIL rstmid_post cyc %0d: got %b expected %b", cyc, obs, expv); end
         if (obs[0]) dones++;
      end
      n_checks++;
      if (dones !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d expected 0", dones); end
      en_req[0] = 1'b0;
   endtask

   task automatic test_random();
      int rc = read_cnt[0];
      garbage[0] = 1'b1;
      for (int k = 0; k < 6; k++) q0.push_back(8'($urandom));
      en_req[0] = 1'b1;
      repeat (6 * 41 + 20) begin
         step();
         n_checks++;
         if (obs !== expv) begin n_fail++; $display("FAIL random cyc %0d: got %b expected %b", cyc, obs, expv); end
      end
      en_req[0] = 1'b0;
      garbage[0] = 1'b0;
      n_checks++;
      if (read_cnt[0] - rc !== 6) begin n_fail++; $display("FAIL random_reads: got %0d expected 6", read_cnt[0] - rc); end
   endtask

   initial begin
      rst        = 1'b1;
      tx_en      = 2'b00;
      fifo_empty = 2'b11;
      fifo_dout  = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_parity();
      test_tx_en();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
